phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer
// Brief    : Five-phase instruction sequencer with memory-wait phase, single-
//            step and halt handling, and a wrapping retired-instruction count.
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
    parameter int CNT_W     = 16,
    parameter int MEM_PHASE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             halt,
    input  logic             mem_ready,
    output logic [4:0]       phase,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_P1     = 3'd1;
    localparam logic [2:0] c_P2     = 3'd2;
    localparam logic [2:0] c_P3     = 3'd3;
    localparam logic [2:0] c_P4     = 3'd4;
    localparam logic [2:0] c_P5     = 3'd5;
    localparam logic [2:0] c_HALTED = 3'd6;

    // Phase numbers map directly onto state codes P1..P5.
    localparam logic [2:0] c_MEM_STATE = 3'(MEM_PHASE);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             w_stall;
    logic             w_retire;
    logic [4:0]       w_phase_nxt;
    logic [4:0]       r_phase;
    logic             r_running;
    logic             r_halted;
    logic [CNT_W-1:0] r_retired;

    assign w_stall = (r_state == c_MEM_STATE) && !mem_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_P1;
                end
            end
            c_P1, c_P2, c_P3, c_P4: begin
                if (!w_stall) begin
                    w_state_nxt = r_state + 3'd1;
                end
            end
            c_P5: begin
                if (!w_stall) begin
                    w_retire = 1'b1;
                    if (halt) begin
                        w_state_nxt = c_HALTED;
                    end else if (step_mode) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_state_nxt = c_P1;
                    end
                end
            end
            c_HALTED: begin
                w_state_nxt = c_HALTED;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered so they change
    // cleanly on the clock edge alongside the state.
    always_comb begin
        w_phase_nxt = 5'b00000;
        case (w_state_nxt)
            c_P1:    w_phase_nxt = 5'b00001;
            c_P2:    w_phase_nxt = 5'b00010;
            c_P3:    w_phase_nxt = 5'b00100;
            c_P4:    w_phase_nxt = 5'b01000;
            c_P5:    w_phase_nxt = 5'b10000;
            default: w_phase_nxt = 5'b00000;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_phase   <= 5'b00000;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_running <= |w_phase_nxt;
            r_halted  <= (w_state_nxt == c_HALTED);
            r_retired <= r_retired + CNT_W'(w_retire);
        end
    end

    assign phase   = r_phase;
    assign running = r_running;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule
`default_nettype wire
